// File: rtl/cart_dl_pkg.sv
// Shared types and constants for the cart download controller.
// Imported by the FIFO and the top-level controller.
package cart_dl_pkg;

  localparam int CART_BYTES = 32768;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_DRAIN,
    S_RST,
    S_WAIT_SKIP
  } state_e;

  typedef struct packed {
    logic [14:0] addr;
    logic [7:0]  data;
  } entry_t;

endpackage

// File: rtl/dl_fifo.sv
// Small synchronous FIFO buffering ioctl bytes ahead of SDRAM writes.
// DEPTH must be a power of two so pointers wrap naturally.
module dl_fifo
  import cart_dl_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk_sys,
  input  logic                   reset_n,
  input  logic                   push,
  input  entry_t                 wdata,
  input  logic                   pop,
  output entry_t                 rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  entry_t        mem_q [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          do_push, do_pop;

  assign full    = cnt_q == (AW+1)'(DEPTH);
  assign empty   = cnt_q == '0;
  assign count   = cnt_q;
  assign rdata   = mem_q[rptr_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (do_push) wptr_d = wptr_q + 1'b1;
    if (do_pop)  rptr_d = rptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
      if (do_push) mem_q[wptr_q] <= wdata;
    end
  end

endmodule

// File: rtl/cart_dl_ctrl.sv
// ioctl-to-SDRAM cart loader: paced writes, port mux, cart size
// tracking and core reset sequencing with optional logo-skip reset.
module cart_dl_ctrl
  import cart_dl_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int CART_BYTES = cart_dl_pkg::CART_BYTES,
  parameter int RESET_LEN  = 1000,
  parameter int SKIP_DELAY = 5000000
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        ioctl_download,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  input  logic        skip_logo,
  input  logic        user_reset,
  input  logic        cart_rd,
  input  logic [14:0] cart_addr,
  output logic [24:0] mem_addr,
  output logic [15:0] mem_din,
  output logic        mem_we,
  output logic        mem_rd,
  input  logic        mem_ack,
  output logic        core_reset,
  output logic [15:0] cart_size,
  output logic        busy,
  output logic        overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);

  state_e      state_q, state_d;
  logic [31:0] timer_q, timer_d;
  logic        first_q, first_d;
  logic        pend_q, pend_d;
  logic        dl_q;
  logic [15:0] size_q, size_d;
  logic        ovf_q, ovf_d;

  logic        dl_rise, in_win, push, pop;
  logic        full, empty, busy_w;
  logic [15:0] end_addr;
  logic [AW:0] fifo_cnt;
  entry_t      head, wentry;

  assign dl_rise  = ioctl_download && !dl_q;
  assign in_win   = ioctl_addr < 25'(CART_BYTES);
  assign push     = ioctl_download && ioctl_wr && in_win;
  assign busy_w   = (state_q == S_LOAD) || (state_q == S_DRAIN);
  assign pop      = busy_w && pend_q && mem_ack;
  assign end_addr = {1'b0, ioctl_addr[14:0]} + 16'd1;
  assign wentry   = '{addr: ioctl_addr[14:0], data: ioctl_dout};

  dl_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .push    (push),
    .wdata   (wentry),
    .pop     (pop),
    .rdata   (head),
    .full    (full),
    .empty   (empty),
    .count   (fifo_cnt)
  );

  always_comb begin
    size_d = dl_rise ? 16'd0 : size_q;
    ovf_d  = dl_rise ? 1'b0 : ovf_q;
    if (push && !full && end_addr > size_d) size_d = end_addr;
    if (push && full) ovf_d = 1'b1;
  end

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    first_d = first_q;
    pend_d  = pend_q;
    if (busy_w) begin
      if (pend_q) begin
        if (mem_ack) pend_d = 1'b0;
      end else if (!empty) begin
        pend_d = 1'b1;
      end
    end
    unique case (state_q)
      S_IDLE: begin
        if (user_reset) begin
          state_d = S_RST;
          timer_d = '0;
          first_d = 1'b0;
        end
      end
      S_LOAD: begin
        if (!ioctl_download) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (fifo_cnt == '0 && !pend_q) begin
          state_d = S_RST;
          timer_d = '0;
          first_d = 1'b1;
        end
      end
      S_RST: begin
        if (user_reset) begin
          timer_d = '0;
        end else if (timer_q == 32'(RESET_LEN - 1)) begin
          timer_d = '0;
          first_d = 1'b0;
          state_d = (first_q && skip_logo) ? S_WAIT_SKIP : S_IDLE;
        end else begin
          timer_d = timer_q + 32'd1;
        end
      end
      S_WAIT_SKIP: begin
        if (user_reset || timer_q == 32'(SKIP_DELAY - 1)) begin
          state_d = S_RST;
          timer_d = '0;
          first_d = 1'b0;
        end else begin
          timer_d = timer_q + 32'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // A new download pre-empts any reset or logo-skip wait
    if (dl_rise) begin
      state_d = S_LOAD;
      timer_d = '0;
      first_d = 1'b0;
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      timer_q <= '0;
      first_q <= 1'b0;
      pend_q  <= 1'b0;
      dl_q    <= 1'b0;
      size_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      first_q <= first_d;
      pend_q  <= pend_d;
      dl_q    <= ioctl_download;
      size_q  <= size_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy       = busy_w;
  assign core_reset = busy_w || (state_q == S_RST);
  assign mem_we     = busy_w && pend_q;
  assign mem_rd     = !busy_w && cart_rd;
  assign mem_addr   = busy_w ? {10'b0, head.addr} : {10'b0, cart_addr};
  assign mem_din    = busy_w ? {head.data, head.data} : 16'd0;
  assign cart_size  = size_q;
  assign overflow   = ovf_q;

endmodule

// File: tb/tb_cart_dl_ctrl.sv
// Self-checking bench for cart_dl_ctrl: SDRAM ack model with
// write scoreboard, idle mux vector table and reset-sequence timing.
module tb_cart_dl_ctrl;

  localparam int RLEN = 1000;
  localparam int SKIP = 100;

  typedef struct {
    logic [24:0] ea;
    logic [15:0] ed;
  } exp_wr_t;

  typedef struct {
    logic        rd;
    logic [14:0] addr;
    logic [24:0] exp_addr;
    logic        exp_rd;
  } vec_t;

  logic        clk_sys = 1'b0;
  logic        reset_n = 1'b0;
  logic        ioctl_download = 1'b0;
  logic        ioctl_wr = 1'b0;
  logic [24:0] ioctl_addr = '0;
  logic [7:0]  ioctl_dout = '0;
  logic        skip_logo = 1'b0;
  logic        user_reset = 1'b0;
  logic        cart_rd = 1'b0;
  logic [14:0] cart_addr = '0;
  logic [24:0] mem_addr;
  logic [15:0] mem_din;
  logic        mem_we;
  logic        mem_rd;
  logic        mem_ack = 1'b0;
  logic        core_reset;
  logic [15:0] cart_size;
  logic        busy;
  logic        overflow;

  always #5 clk_sys = ~clk_sys;

  cart_dl_ctrl #(
    .FIFO_DEPTH (4),
    .CART_BYTES (32768),
    .RESET_LEN  (RLEN),
    .SKIP_DELAY (SKIP)
  ) dut (
    .clk_sys        (clk_sys),
    .reset_n        (reset_n),
    .ioctl_download (ioctl_download),
    .ioctl_wr       (ioctl_wr),
    .ioctl_addr     (ioctl_addr),
    .ioctl_dout     (ioctl_dout),
    .skip_logo      (skip_logo),
    .user_reset     (user_reset),
    .cart_rd        (cart_rd),
    .cart_addr      (cart_addr),
    .mem_addr       (mem_addr),
    .mem_din        (mem_din),
    .mem_we         (mem_we),
    .mem_rd         (mem_rd),
    .mem_ack        (mem_ack),
    .core_reset     (core_reset),
    .cart_size      (cart_size),
    .busy           (busy),
    .overflow       (overflow)
  );

  int      total = 0;
  int      bad = 0;
  int      ack_delay = 3;
  int      wr_cnt = 0;
  int      ack_cnt = 0;
  exp_wr_t sb[$];

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // SDRAM model: ack a held mem_we after ack_delay cycles, check it
  initial begin : sdram
    exp_wr_t e;
    forever begin
      @(negedge clk_sys);
      if (mem_ack) begin
        mem_ack = 1'b0;
      end else if (mem_we) begin
        ack_cnt++;
        if (ack_cnt >= ack_delay) begin
          ack_cnt = 0;
          mem_ack = 1'b1;
          wr_cnt++;
          if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_write: got addr %0h din %0h want none",
                     mem_addr, mem_din);
          end else begin
            e = sb.pop_front();
            check("wr_addr", mem_addr, e.ea);
            check("wr_din", mem_din, e.ed);
          end
        end
      end else begin
        ack_cnt = 0;
      end
    end
  end

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic send(input logic [24:0] a, input logic [7:0] d,
                      input bit acc);
    exp_wr_t e;
    ioctl_addr = a;
    ioctl_dout = d;
    ioctl_wr   = 1'b1;
    if (acc) begin
      e.ea = {10'b0, a[14:0]};
      e.ed = {d, d};
      sb.push_back(e);
    end
    tick();
    ioctl_wr = 1'b0;
  endtask

  task automatic wait_busy_low(input int bound, input string name);
    int n = 0;
    while (busy && n < bound) begin
      tick();
      n++;
    end
    check(name, busy, 0);
  endtask

  task automatic count_level(input logic lvl, input int bound,
                             output int n);
    n = 0;
    while (core_reset == lvl && n < bound) begin
      n++;
      tick();
    end
  endtask

  vec_t vecs[4];
  int   n;

  initial begin
    vecs[0] = '{rd: 1'b1, addr: 15'h1234, exp_addr: 25'h0001234, exp_rd: 1'b1};
    vecs[1] = '{rd: 1'b0, addr: 15'h1234, exp_addr: 25'h0001234, exp_rd: 1'b0};
    vecs[2] = '{rd: 1'b1, addr: 15'h7FFF, exp_addr: 25'h0007FFF, exp_rd: 1'b1};
    vecs[3] = '{rd: 1'b1, addr: 15'h0000, exp_addr: 25'h0000000, exp_rd: 1'b1};

    ticks(3);
    check("rst_core_reset", core_reset, 0);
    check("rst_busy", busy, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_mem_rd", mem_rd, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_din", mem_din, 0);
    check("rst_cart_size", cart_size, 0);
    check("rst_overflow", overflow, 0);
    reset_n = 1'b1;
    tick();

    // Paced download of 16 bytes
    ack_delay = 3;
    wr_cnt = 0;
    ioctl_download = 1'b1;
    tick();
    check("t1_load_core_reset", core_reset, 1);
    check("t1_load_busy", busy, 1);
    check("t1_load_rd_gated", mem_rd, 0);
    for (int i = 0; i < 16; i++) begin
      send(25'(i), 8'(i * 37 + 5), 1'b1);
      ticks(7);
    end
    ioctl_download = 1'b0;
    wait_busy_low(100, "t1_drain_timeout");
    count_level(1'b1, 3000, n);
    check("t1_reset_len", n, RLEN);
    check("t1_writes", wr_cnt, 16);
    check("t1_sb_left", sb.size(), 0);
    check("t1_cart_size", cart_size, 16);
    check("t1_overflow", overflow, 0);

    // Burst into a slow SDRAM overflows the FIFO
    ack_delay = 20;
    wr_cnt = 0;
    ioctl_download = 1'b1;
    tick();
    for (int j = 0; j < 6; j++) send(25'(32'h100 + j), 8'(8'hA0 + j), j < 4);
    check("t2_overflow", overflow, 1);
    check("t2_cart_size", cart_size, 16'h104);
    ioctl_download = 1'b0;
    wait_busy_low(300, "t2_drain_timeout");
    count_level(1'b1, 3000, n);
    check("t2_writes", wr_cnt, 4);
    check("t2_sb_left", sb.size(), 0);

    // Cart window boundary; new download clears overflow
    ack_delay = 3;
    wr_cnt = 0;
    ioctl_download = 1'b1;
    tick();
    check("t4_ovf_cleared", overflow, 0);
    check("t4_size_cleared", cart_size, 0);
    send(25'h8000, 8'h33, 1'b0);
    send(25'h7FFF, 8'h5A, 1'b1);
    ticks(10);
    ioctl_download = 1'b0;
    wait_busy_low(100, "t4_drain_timeout");
    count_level(1'b1, 3000, n);
    check("t4_writes", wr_cnt, 1);
    check("t4_cart_size", cart_size, 16'h8000);
    check("t4_overflow", overflow, 0);

    // Logo skip: two reset pulses separated by SKIP cycles
    skip_logo = 1'b1;
    ioctl_download = 1'b1;
    tick();
    send(25'h5, 8'h77, 1'b1);
    ticks(8);
    ioctl_download = 1'b0;
    wait_busy_low(100, "t3_drain_timeout");
    count_level(1'b1, 3000, n);
    check("t3_pulse1_len", n, RLEN);
    count_level(1'b0, 3000, n);
    check("t3_gap_len", n, SKIP);
    count_level(1'b1, 3000, n);
    check("t3_pulse2_len", n, RLEN);
    count_level(1'b0, 300, n);
    check("t3_no_third", n, 300);

    // Idle port mux vectors
    for (int k = 0; k < 4; k++) begin
      cart_rd = vecs[k].rd;
      cart_addr = vecs[k].addr;
      #1;
      check($sformatf("t5_mem_addr_%0d", k), mem_addr, vecs[k].exp_addr);
      check($sformatf("t5_mem_rd_%0d", k), mem_rd, vecs[k].exp_rd);
      check($sformatf("t5_busy_%0d", k), busy, 0);
      check($sformatf("t5_mem_we_%0d", k), mem_we, 0);
    end

    // User reset, restarted halfway; no logo-skip second pass
    user_reset = 1'b1;
    tick();
    user_reset = 1'b0;
    check("t5_ureset_start", core_reset, 1);
    ticks(499);
    check("t5_ureset_mid", core_reset, 1);
    user_reset = 1'b1;
    tick();
    user_reset = 1'b0;
    count_level(1'b1, 3000, n);
    check("t5_restart_len", n, RLEN);
    count_level(1'b0, 300, n);
    check("t5_no_second", n, 300);

    // Async reset while a write awaits ack
    skip_logo = 1'b0;
    cart_rd = 1'b0;
    ack_delay = 50;
    wr_cnt = 0;
    ioctl_download = 1'b1;
    tick();
    send(25'h3, 8'h99, 1'b1);
    n = 0;
    while (!mem_we && n < 10) begin
      tick();
      n++;
    end
    check("t6_we_up", mem_we, 1);
    reset_n = 1'b0;
    ioctl_download = 1'b0;
    #1;
    check("t6_we_dropped", mem_we, 0);
    check("t6_busy_dropped", busy, 0);
    check("t6_core_reset", core_reset, 0);
    sb.delete();
    ticks(2);
    reset_n = 1'b1;
    ticks(3);
    check("t6_idle_busy", busy, 0);
    check("t6_idle_core_reset", core_reset, 0);
    check("t6_size_cleared", cart_size, 0);
    cart_rd = 1'b1;
    cart_addr = 15'h55;
    #1;
    check("t6_idle_mem_rd", mem_rd, 1);
    check("t6_idle_mem_addr", mem_addr, 25'h55);
    ticks(60);
    check("t6_no_write", wr_cnt, 0);
    check("sb_left", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cart_dl_ctrl.md
Name: cart_dl_ctrl

Overview:
- Sits between the mist_io ioctl download port and the SDRAM cart memory.
- Buffers downloaded ROM bytes and issues paced SDRAM writes with a request/acknowledge handshake.
- Muxes the SDRAM port between the loader and the core's cart reads, records the loaded cart size, and generates the core reset sequence, including the delayed second reset used to skip the boot logo.

Parameters:
- FIFO_DEPTH, 4, byte/address entries buffered between ioctl and SDRAM (power of two).
- CART_BYTES, 32768, cart window; bytes at ioctl_addr >= CART_BYTES are discarded.
- RESET_LEN, 1000, core_reset hold length in clk_sys cycles after each reset trigger.
- SKIP_DELAY, 5000000, cycles from end of first reset to the second (logo-skip) reset.

Ports:
- clk_sys  in  1  system clock (24 MHz)
- reset_n  in  1  asynchronous active-low reset
- ioctl_download  in  1  download window active
- ioctl_wr  in  1  one-cycle byte strobe
- ioctl_addr  in  25  byte address
- ioctl_dout  in  8  byte data
- skip_logo  in  1  1 = issue second reset after download
- user_reset  in  1  OSD/button reset request, level
- cart_rd  in  1  core read strobe
- cart_addr  in  15  core read address
- mem_addr  out  25  SDRAM address
- mem_din  out  16  SDRAM write data, byte duplicated on both halves
- mem_we  out  1  write request, held until mem_ack
- mem_rd  out  1  read request
- mem_ack  in  1  one-cycle write-complete pulse from SDRAM
- core_reset  out  1  active-high reset to vectrex core
- cart_size  out  16  loaded byte count, 0..CART_BYTES
- busy  out  1  loader owns SDRAM port
- overflow  out  1  sticky: a byte was dropped because the FIFO was full

Behaviour:
- All outputs reset to 0. FIFO is empty, FSM is in IDLE, timers are 0.
- FIFO: pushes on ioctl_download & ioctl_wr & (ioctl_addr < CART_BYTES) & !full; each entry is {addr[14:0], data}.
  - Push while full drops the byte and sets overflow.
  - Simultaneous push and pop are legal, and the count is unchanged.
- FSM states: IDLE, LOAD, DRAIN, RST, WAIT_SKIP.
  - IDLE -> LOAD on rising ioctl_download. This clears cart_size and overflow and sets busy=1.
  - LOAD: while the FIFO is non-empty and no write is outstanding, present the head entry on mem_addr/mem_din and assert mem_we. Pop and deassert mem_we in the cycle mem_ack=1. mem_we never drops before mem_ack. The next write may start the following cycle.
  - LOAD -> DRAIN on falling ioctl_download.
  - DRAIN -> RST when the FIFO is empty and no write is outstanding. busy=0 on entry to RST.
  - RST: hold core_reset=1 for RESET_LEN cycles. Then go to WAIT_SKIP if skip_logo and this RST followed a download (first pass), otherwise to IDLE.
  - WAIT_SKIP: count SKIP_DELAY cycles, then enter RST again (second pass, which returns to IDLE).
- core_reset=1 throughout LOAD, DRAIN and RST.
- user_reset=1 in IDLE or WAIT_SKIP enters RST with no second pass. The WAIT_SKIP timer is cancelled.
- user_reset during RST restarts the RESET_LEN count.
- Rising ioctl_download in any state aborts timers and enters LOAD.
- cart_size: on each accepted push, cart_size <= max(cart_size, addr+1). It saturates at CART_BYTES.
- Port mux: when busy=1, mem_addr comes from the FIFO and mem_rd=0. Otherwise mem_addr={10'b0,cart_addr}, mem_rd=cart_rd and mem_we=0. Mux outputs are combinational from registered state.
- Deasserting reset_n mid-download discards the FIFO, deasserts mem_we immediately and returns to IDLE. The host must re-download.

Decomposition:
- Package cart_dl_pkg: FSM state enum, entry typedef {logic[14:0] addr; logic[7:0] data}, CART_BYTES constant.
- One sub-module: dl_fifo, a synchronous FIFO of FIFO_DEPTH entries with full/empty/count, same clk_sys/reset_n.

Test Plan:
- Download 16 bytes, one every 8 cycles, mem_ack 3 cycles after mem_we -> 16 SDRAM writes with correct addr/data (mem_din = {d,d}); cart_size=16; core_reset high then exactly 1000 cycles after drain; overflow=0.
- Burst 6 ioctl_wr on consecutive cycles with mem_ack delayed 20 cycles -> 4 bytes accepted, 2 dropped, overflow=1; next download start clears overflow.
- skip_logo=1 (SKIP_DELAY=100 in bench) -> core_reset pulse of 1000 cycles, then 100 low cycles, then a second 1000-cycle pulse, then IDLE.
- ioctl_addr=0x8000 and 0x7FFF written -> only 0x7FFF written to SDRAM; cart_size=32768.
- Idle with cart_rd=1, cart_addr=0x1234 -> mem_addr=0x0001234, mem_rd=1, busy=0; user_reset pulse -> core_reset high for 1000 cycles, no second pulse.
- reset_n low while mem_we=1 awaiting ack -> mem_we=0 and busy=0 immediately; FSM in IDLE after release.
